// File: rtl/lane_deskew_fifo_bank.sv
// Per-lane 66-bit block FIFOs with independent read/write enables,
// so early lanes can be held until the latest lane arrives.
module lane_deskew_fifo_bank #(
  parameter int NB_WORD    = 66,
  parameter int FIFO_DEPTH = 16,
  parameter int NB_ADDR    = $clog2(FIFO_DEPTH),
  parameter int NB_LEVEL   = NB_ADDR + 1,
  parameter int N_LANES    = 20
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_flush,
  input  logic                         i_clear_errors,
  input  logic [N_LANES-1:0]           i_write_enable,
  input  logic [N_LANES*NB_WORD-1:0]   i_data,
  input  logic [N_LANES-1:0]           i_read_enable,
  output logic [N_LANES*NB_WORD-1:0]   o_data,
  output logic [N_LANES-1:0]           o_valid,
  output logic [N_LANES-1:0]           o_empty,
  output logic [N_LANES-1:0]           o_full,
  output logic [N_LANES*NB_LEVEL-1:0]  o_level,
  output logic [N_LANES-1:0]           o_overflow,
  output logic [N_LANES-1:0]           o_underflow
);

  localparam logic [NB_LEVEL-1:0] LP_FULL = NB_LEVEL'(FIFO_DEPTH);
  localparam logic [NB_LEVEL-1:0] LP_ONE  = NB_LEVEL'(1);
  localparam logic [NB_ADDR-1:0]  LP_INC  = NB_ADDR'(1);

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic [NB_WORD-1:0]  r_mem [FIFO_DEPTH];
    logic [NB_ADDR-1:0]  r_wr_ptr;
    logic [NB_ADDR-1:0]  r_rd_ptr;
    logic [NB_LEVEL-1:0] r_level;
    logic [NB_WORD-1:0]  r_data;
    logic                r_valid;
    logic                r_empty;
    logic                r_full;
    logic                r_ovf;
    logic                r_unf;

    logic                w_rd_acc;
    logic                w_wr_acc;
    logic                w_ovf_evt;
    logic                w_unf_evt;
    logic [NB_LEVEL-1:0] w_level_nxt;
    logic [NB_WORD-1:0]  w_wdata;

    assign w_wdata   = i_data[k*NB_WORD +: NB_WORD];
    assign w_rd_acc  = i_read_enable[k] & ~r_empty;
    assign w_wr_acc  = i_write_enable[k] & (~r_full | w_rd_acc);
    assign w_ovf_evt = i_write_enable[k] & r_full & ~w_rd_acc;
    assign w_unf_evt = i_read_enable[k] & r_empty;

    always_comb begin
      w_level_nxt = r_level;
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   w_level_nxt = r_level + LP_ONE;
        2'b01:   w_level_nxt = r_level - LP_ONE;
        default: w_level_nxt = r_level;
      endcase
    end

    // Storage stays unreset so it maps onto RAM.
    always_ff @(posedge i_clock) begin
      if (!i_flush && w_wr_acc) begin
        r_mem[r_wr_ptr] <= w_wdata;
      end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
        r_data   <= '0;
        r_valid  <= 1'b0;
        r_empty  <= 1'b1;
        r_full   <= 1'b0;
        r_ovf    <= 1'b0;
        r_unf    <= 1'b0;
      end else if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
        r_valid  <= 1'b0;
        r_empty  <= 1'b1;
        r_full   <= 1'b0;
      end else begin
        if (w_wr_acc) begin
          r_wr_ptr <= r_wr_ptr + LP_INC;
        end
        if (w_rd_acc) begin
          r_rd_ptr <= r_rd_ptr + LP_INC;
          r_data   <= r_mem[r_rd_ptr];
        end
        r_valid <= w_rd_acc;
        r_level <= w_level_nxt;
        r_empty <= (w_level_nxt == '0);
        r_full  <= (w_level_nxt == LP_FULL);
        r_ovf   <= w_ovf_evt | (r_ovf & ~i_clear_errors);
        r_unf   <= w_unf_evt | (r_unf & ~i_clear_errors);
      end
    end

    assign o_data[k*NB_WORD +: NB_WORD]    = r_data;
    assign o_level[k*NB_LEVEL +: NB_LEVEL] = r_level;
    assign o_valid[k]     = r_valid;
    assign o_empty[k]     = r_empty;
    assign o_full[k]      = r_full;
    assign o_overflow[k]  = r_ovf;
    assign o_underflow[k] = r_unf;
  end

endmodule

// File: tb/tb_lane_deskew_fifo_bank.sv
// Directed bench for lane_deskew_fifo_bank: 4 lanes, depth 16.
module tb_lane_deskew_fifo_bank;

  localparam int W  = 66;
  localparam int D  = 16;
  localparam int NL = 5;
  localparam int N  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic           clr;
  logic [N-1:0]   we;
  logic [N*W-1:0] din;
  logic [N-1:0]   re;
  logic [N*W-1:0] dout;
  logic [N-1:0]   valid;
  logic [N-1:0]   empty;
  logic [N-1:0]   full;
  logic [N*NL-1:0] level;
  logic [N-1:0]   ovf;
  logic [N-1:0]   unf;

  int total = 0;
  int bad   = 0;

  lane_deskew_fifo_bank #(
    .NB_WORD(W), .FIFO_DEPTH(D), .N_LANES(N)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_flush(flush),
    .i_clear_errors(clr),
    .i_write_enable(we),
    .i_data(din),
    .i_read_enable(re),
    .o_data(dout),
    .o_valid(valid),
    .o_empty(empty),
    .o_full(full),
    .o_level(level),
    .o_overflow(ovf),
    .o_underflow(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] seqw(input int k, input int n);
    logic [W-1:0] v;
    v = (W'(k) << 32) | W'(n);
    return v;
  endfunction

  function automatic logic [W-1:0] dat(input int k);
    return dout[k*W +: W];
  endfunction

  function automatic logic [NL-1:0] lvl(input int k);
    return level[k*NL +: NL];
  endfunction

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    clr   = 1'b0;
    we    = '0;
    re    = '0;
    din   = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_empty", W'(empty), W'(4'hF));
    chk("rst_level", W'(level), '0);
    chk("rst_full",  W'(full),  '0);
    chk("rst_valid", W'(valid), '0);
    chk("rst_err",   W'({ovf, unf}), '0);
    chk("rst_data",  dout[W-1:0] | dout[2*W +: W], '0);

    // lane 2: write 1,2,3 then read back
    we = 4'b0100;
    for (int i = 1; i <= 3; i++) begin
      din[2*W +: W] = W'(i);
      tick();
    end
    we = '0;
    chk("l2_level3", W'(lvl(2)), W'(3));
    chk("l2_notempty", W'(empty[2]), W'(0));
    re = 4'b0100;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("l2_rd_valid", W'(valid), W'(4'b0100));
      chk("l2_rd_data", dat(2), W'(i));
    end
    re = '0;
    tick();
    chk("l2_valid_drop", W'(valid[2]), W'(0));
    chk("l2_empty_end", W'(empty[2]), W'(1));
    chk("l2_data_hold", dat(2), W'(3));

    // lane 0: fill, overflow, clear, then read+write on full
    we = 4'b0001;
    for (int i = 0; i < D; i++) begin
      din[0 +: W] = W'(100 + i);
      tick();
    end
    chk("l0_full", W'(full[0]), W'(1));
    chk("l0_lvl16", W'(lvl(0)), W'(16));
    din[0 +: W] = W'(200);
    tick();
    we = '0;
    chk("l0_ovf", W'(ovf), W'(4'b0001));
    chk("l0_lvl_ovf", W'(lvl(0)), W'(16));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("l0_ovf_clr", W'(ovf[0]), W'(0));
    we = 4'b0001;
    re = 4'b0001;
    din[0 +: W] = W'(66'hAA);
    tick();
    we = '0;
    chk("l0_rw_data", dat(0), W'(100));
    chk("l0_rw_valid", W'(valid[0]), W'(1));
    chk("l0_rw_lvl", W'(lvl(0)), W'(16));
    chk("l0_rw_full", W'(full[0]), W'(1));
    chk("l0_rw_noovf", W'(ovf[0]), W'(0));
    for (int i = 1; i <= D; i++) begin
      tick();
      chk("l0_readback", dat(0), (i == D) ? W'(66'hAA) : W'(100 + i));
    end
    re = '0;
    tick();
    chk("l0_empty", W'(empty[0]), W'(1));
    chk("l0_lvl0", W'(lvl(0)), W'(0));

    // lane 3: underflow and sticky clear
    re = 4'b1000;
    tick();
    re = '0;
    chk("l3_unf", W'(unf), W'(4'b1000));
    chk("l3_unf_valid", W'(valid[3]), W'(0));
    chk("l3_unf_data", dat(3), W'(0));
    clr = 1'b1;
    tick();
    chk("l3_clr", W'(unf[3]), W'(0));
    re = 4'b1000;
    tick();
    re  = '0;
    chk("l3_clr_prio", W'(unf[3]), W'(1));
    tick();
    clr = 1'b0;
    chk("l3_clr2", W'(unf), W'(0));

    // deskew: lane 1 leads by 3 cycles, 40 words with wrap
    for (int c = 0; c < 44; c++) begin
      we = '0;
      if (c < 40) begin
        we[1] = 1'b1;
        din[1*W +: W] = seqw(1, c);
      end
      if (c >= 3 && c < 43) begin
        for (int k = 0; k < N; k++) begin
          if (k != 1) begin
            we[k] = 1'b1;
            din[k*W +: W] = seqw(k, c - 3);
          end
        end
      end
      re = (c >= 4) ? 4'hF : 4'h0;
      tick();
      if (c >= 4) begin
        chk("dsk_valid", W'(valid), W'(4'hF));
        for (int k = 0; k < N; k++) begin
          chk("dsk_data", dat(k), seqw(k, c - 4));
        end
      end
    end
    we = '0;
    re = '0;
    tick();
    chk("dsk_err", W'({ovf, unf}), '0);
    chk("dsk_empty", W'(empty), W'(4'hF));

    // levels 5/0/9/16 plus an overflow on lane 3
    for (int c = 0; c < 17; c++) begin
      we = {1'b1, (c < 9), 1'b0, (c < 5)};
      for (int k = 0; k < N; k++) din[k*W +: W] = W'(500 + c);
      tick();
    end
    we = '0;
    chk("pre_flush_lvl", W'(level), W'({5'd16, 5'd9, 5'd0, 5'd5}));
    chk("pre_flush_ovf", W'(ovf), W'(4'b1000));
    flush = 1'b1;
    we = 4'hF;
    re = 4'hF;
    tick();
    flush = 1'b0;
    we = '0;
    re = '0;
    chk("flush_lvl", W'(level), '0);
    chk("flush_empty", W'(empty), W'(4'hF));
    chk("flush_full", W'(full), '0);
    chk("flush_valid", W'(valid), '0);
    chk("flush_ovf", W'(ovf), W'(4'b1000));
    chk("flush_unf", W'(unf), '0);
    for (int k = 0; k < N; k++) begin
      chk("flush_data", dat(k), seqw(k, 39));
    end

    // one word through lane 0, then async reset mid-cycle
    we = 4'b0001;
    din[0 +: W] = W'(66'h3_0000_0000_0000_0077);
    tick();
    we = '0;
    re = 4'b0001;
    tick();
    re = '0;
    chk("post_flush_rd", dat(0), W'(66'h3_0000_0000_0000_0077));
    chk("post_flush_valid", W'(valid[0]), W'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", W'(valid), '0);
    chk("arst_data", dat(0), '0);
    chk("arst_empty", W'(empty), W'(4'hF));
    chk("arst_ovf", W'(ovf), '0);
    chk("arst_lvl", W'(level), '0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_deskew_fifo_bank.md
Name: lane_deskew_fifo_bank

Overview:
Bank of N_LANES independent synchronous FIFOs, one per PCS lane, for 66-bit blocks. Each lane has its own write and read enables, so the lane alignment/deskew logic can hold early lanes until the latest lane arrives and then read all lanes in lockstep. Each lane has registered read data, per-lane level, full and empty flags, and sticky overflow/underflow error flags. Sits between the lane-alignment-marker lock stage and the lane reorder/deskew stage.

Parameters:
NB_WORD, 66, width of one stored block in bits
FIFO_DEPTH, 16, entries per lane; must be a power of 2 and at least 2
NB_ADDR, $clog2(FIFO_DEPTH), pointer width
NB_LEVEL, NB_ADDR+1, width of the per-lane occupancy count
N_LANES, 20, number of independent lane FIFOs

Ports:
i_clock  in  1  rising-edge clock for all state
i_reset_n  in  1  asynchronous reset, active low
i_flush  in  1  synchronous flush of all lanes
i_clear_errors  in  1  synchronous clear of the sticky error flags
i_write_enable  in  N_LANES  per-lane write request
i_data  in  N_LANES*NB_WORD  write data; lane k occupies bits [k*NB_WORD +: NB_WORD]
i_read_enable  in  N_LANES  per-lane read request
o_data  out  N_LANES*NB_WORD  registered read data; same packing as i_data
o_valid  out  N_LANES  o_data lane k is fresh this cycle
o_empty  out  N_LANES  lane level == 0
o_full  out  N_LANES  lane level == FIFO_DEPTH
o_level  out  N_LANES*NB_LEVEL  lane occupancy, 0..FIFO_DEPTH
o_overflow  out  N_LANES  sticky: write dropped on full lane
o_underflow  out  N_LANES  sticky: read requested on empty lane

Behaviour:
- Reset (i_reset_n low, asynchronous): all pointers and levels = 0, o_data = 0, o_valid = 0, o_empty = all 1, o_full = 0, o_overflow = 0, o_underflow = 0. Memory contents are not reset.
- Per lane, the following rules apply independently with no cross-lane coupling except i_flush and i_clear_errors.
- Read accepted = i_read_enable & !empty. Write accepted = i_write_enable & (!full | read accepted).
  - A full lane with simultaneous read and write accepts both. Level stays at FIFO_DEPTH.
  - An empty lane with simultaneous read and write accepts the write only. The read is an underflow.
  - There is no write-through to the output.
- Accepted write: mem[wr_ptr] <= data; wr_ptr increments modulo FIFO_DEPTH (natural wrap).
- Accepted read: o_data lane <= mem[rd_ptr] at the next edge; rd_ptr increments modulo FIFO_DEPTH; o_valid lane = 1 for exactly that one cycle. Read latency is 1 clock.
- No accepted read: o_valid lane = 0 and o_data lane holds its previous value.
- Level: +1 on write only, -1 on read only, unchanged on both or neither. o_empty, o_full and o_level are registered and consistent with the level after the edge.
- Overflow: i_write_enable on a full lane without an accepted read sets o_overflow[k]. The data is dropped; pointers and level are unchanged.
- Underflow: i_read_enable on an empty lane sets o_underflow[k]. o_valid[k] stays 0 and o_data[k] is unchanged.
- i_clear_errors clears all sticky flags. An error event in the same cycle has priority and the flag reads 1 afterwards.
- i_flush (synchronous, all lanes): pointers = 0, level = 0, o_valid = 0. All reads and writes that cycle are discarded. o_data and the error flags are unchanged. No overflow or underflow is flagged in a flush cycle.
- Priority order: reset > flush > normal operation.
- Storage is inferred as block or distributed RAM per lane: one write port and one registered read port, no read-during-write bypass.

Test Plan:
- Reset / basic write-read (N_LANES=4, FIFO_DEPTH=16): after reset check o_empty=4'hF, o_level all 0. Write lane 2 with 66'h1, 66'h2, 66'h3 -> level[2]=3. Read 3 cycles -> o_data[2] = 1, 2, 3 with o_valid[2] high one cycle after each read. Final empty[2]=1.
- Full and overflow: write 16 words into lane 0 -> o_full[0]=1, level 16. A 17th write with no read -> o_overflow[0]=1, level stays 16. Readback returns the first 16 values in order.
- Simultaneous read/write on full: lane 0 at level 16, write 66'hAA with a read in the same cycle -> both accepted, level 16, no overflow. 66'hAA is the last word read back.
- Underflow and clear: read on empty lane 3 -> o_underflow[3]=1, o_valid[3]=0. Assert i_clear_errors alone -> flag 0. Assert i_clear_errors together with another empty read -> flag stays 1.
- Wrap-around / deskew: lane 1 is written 3 cycles before lanes 0, 2 and 3. Keep the pointers running across 40 words. Read all lanes together once every lane is non-empty -> all 4 lanes give o_valid the same cycle with matching sequence numbers. No errors.
- Flush and async reset mid-stream: with lanes at levels 5/0/9/16, i_flush=1 while writing -> all levels 0, o_valid 0, error flags unchanged. Then pull i_reset_n low mid-cycle -> outputs return to reset values immediately, without waiting for a clock edge.
